// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax row normaliser.
// State encoding, default datapath widths and a constant-foldable clog2.
package softmax_pkg;
    typedef enum logic [1:0] {FILL, DIV, OUT} state_t;

    localparam int EX_W_DEF   = 9;
    localparam int PROB_W_DEF = 8;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/softmax_row_ctrl_if.sv
// Score-in / probability-out handshake bundle for softmax_row_ctrl.
// slave = the row controller's view, master = the producer/consumer side.
interface softmax_row_ctrl_if
    import softmax_pkg::*;
#(
    parameter int EX_W   = EX_W_DEF,
    parameter int PROB_W = PROB_W_DEF
);
    logic [EX_W-1:0]   ex_slv_in;
    logic              vld_slv_in;
    logic              rdy_slv_out;
    logic [PROB_W-1:0] prob_mst_out;
    logic              last_mst_out;
    logic              vld_mst_out;
    logic              rdy_mst_in;

    modport slave (
        input  ex_slv_in, vld_slv_in, rdy_mst_in,
        output rdy_slv_out, prob_mst_out, last_mst_out, vld_mst_out
    );

    modport master (
        output ex_slv_in, vld_slv_in, rdy_mst_in,
        input  rdy_slv_out, prob_mst_out, last_mst_out, vld_mst_out
    );
endinterface

// File: rtl/softmax_row_ctrl_serial_div.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// The first bit is resolved in the start cycle, and done/quo_o are combinational on the last step.
module serial_div
    import softmax_pkg::*;
#(
    parameter int NUM_W = 17,
    parameter int DEN_W = 11,
    parameter int Q_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Q_W-1:0]   quo_o
);
    localparam int CNT_W = clog2(Q_W + 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DEN_W-1:0] rem_q, den_q, rem_src, den_src, rem_nx;
    logic [Q_W-1:0]   num_q, quo_q, quo_src;
    logic             bit_src, ge;
    logic [DEN_W:0]   trial;

    // Bits above the quotient field seed the remainder; they are below den whenever the quotient fits Q_W bits.
    always_comb begin
        rem_src = start_i ? DEN_W'(num_i[NUM_W-1:Q_W]) : rem_q;
        bit_src = start_i ? num_i[Q_W-1] : num_q[Q_W-1];
        den_src = start_i ? den_i : den_q;
        quo_src = start_i ? '0 : quo_q;
        trial   = {rem_src, bit_src};
        ge      = (trial >= {1'b0, den_src});
        rem_nx  = ge ? DEN_W'(trial - {1'b0, den_src}) : trial[DEN_W-1:0];
    end

    assign quo_o  = {quo_src[Q_W-2:0], ge};
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            num_q  <= '0;
            quo_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(Q_W - 1);
            rem_q  <= rem_nx;
            den_q  <= den_i;
            num_q  <= num_i[Q_W-1:0] << 1;
            quo_q  <= quo_o;
        end else if (busy_q) begin
            rem_q <= rem_nx;
            num_q <= num_q << 1;
            quo_q <= quo_o;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/softmax_row_ctrl.sv
// Buffers one row of e^x scores, sums them, then emits each score / sum as UQ0.8.
// Optional status outputs err_zero_sum/row_cnt exist when SOFTMAX_STATUS_EN is defined.
module softmax_row_ctrl
    import softmax_pkg::*;
#(
    parameter int ROW_LEN = 4,
    parameter int EX_W    = EX_W_DEF,
    parameter int PROB_W  = PROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    softmax_row_ctrl_if.slave bus
`ifdef SOFTMAX_STATUS_EN
    ,
    output logic              err_zero_sum,
    output logic [7:0]        row_cnt
`endif
);
    localparam int IDX_W = clog2(ROW_LEN);
    localparam int SUM_W = EX_W + IDX_W;
    localparam int NUM_W = EX_W + PROB_W;
    localparam int Q_W   = PROB_W + 1;

    state_t                       state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [SUM_W-1:0]             sum_q, sum_d;
    logic [ROW_LEN-1:0][EX_W-1:0] sbuf_q;
    logic [PROB_W-1:0]            prob_q, prob_sat;
    logic                         last_q, last_idx;
    logic                         div_start, div_busy, div_done;
    logic [Q_W-1:0]               div_quo;

    assign sum_d     = sum_q + SUM_W'(bus.ex_slv_in);
    assign last_idx  = (idx_q == IDX_W'(ROW_LEN - 1));
    assign div_start = (state_q == DIV) && !div_busy;
    // A quotient of exactly 2^PROB_W means one score owns the whole row.
    assign prob_sat  = div_quo[PROB_W] ? '1 : div_quo[PROB_W-1:0];

    serial_div #(.NUM_W(NUM_W), .DEN_W(SUM_W), .Q_W(Q_W)) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .num_i   ({sbuf_q[idx_q], {PROB_W{1'b0}}}),
        .den_i   (sum_q),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            sum_q   <= '0;
            sbuf_q  <= '0;
            prob_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: if (bus.vld_slv_in) begin
                    sbuf_q[idx_q] <= bus.ex_slv_in;
                    sum_q         <= sum_d;
                    if (last_idx) begin
                        idx_q   <= '0;
                        prob_q  <= '0;
                        last_q  <= 1'b0;
                        state_q <= (sum_d == '0) ? OUT : DIV;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DIV: if (div_done) begin
                    prob_q  <= prob_sat;
                    last_q  <= last_idx;
                    state_q <= OUT;
                end
                OUT: if (bus.rdy_mst_in) begin
                    prob_q <= '0;
                    if (last_q) begin
                        sum_q   <= '0;
                        idx_q   <= '0;
                        last_q  <= 1'b0;
                        state_q <= FILL;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        last_q  <= (idx_q == IDX_W'(ROW_LEN - 2));
                        state_q <= (sum_q == '0) ? OUT : DIV;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.rdy_slv_out  = (state_q == FILL);
    assign bus.vld_mst_out  = (state_q == OUT);
    assign bus.prob_mst_out = prob_q;
    assign bus.last_mst_out = last_q;

`ifdef SOFTMAX_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_zero_sum <= 1'b0;
            row_cnt      <= '0;
        end else begin
            if (state_q == FILL && bus.vld_slv_in && last_idx && sum_d == '0) err_zero_sum <= 1'b1;
            if (state_q == OUT && bus.rdy_mst_in && last_q) row_cnt <= row_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_softmax_row_ctrl.sv
// Directed bench for softmax_row_ctrl: reset, zero row, uniform, dominant, gaps, backpressure, mid-DIV reset.
// Status checks compile in when SOFTMAX_STATUS_EN is defined.
module tb_softmax_row_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    softmax_row_ctrl_if #(.EX_W(9), .PROB_W(8)) bus ();

`ifdef SOFTMAX_STATUS_EN
    logic       err_zero_sum;
    logic [7:0] row_cnt;
`endif

    softmax_row_ctrl #(.ROW_LEN(4), .EX_W(9), .PROB_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SOFTMAX_STATUS_EN
        ,
        .err_zero_sum (err_zero_sum),
        .row_cnt      (row_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; the score is accepted at the following posedge (cycle t).
    task automatic push(input logic [8:0] v, output int t);
        bus.ex_slv_in  = v;
        bus.vld_slv_in = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.vld_slv_in = 1'b0;
    endtask

    task automatic wait_vld(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.vld_mst_out === 1'b1) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (bus.rdy_slv_out !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", bus.rdy_slv_out); end
        total++; if (bus.vld_mst_out !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", bus.vld_mst_out); end
        total++; if (bus.last_mst_out !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", bus.last_mst_out); end
        total++; if (bus.prob_mst_out !== 8'd0) begin bad++; $display("FAIL reset_prob: got %0d want 0", bus.prob_mst_out); end
`ifdef SOFTMAX_STATUS_EN
        total++; if (err_zero_sum !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_zero_sum); end
        total++; if (row_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", row_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_row;
        int t, c, u;
        for (int k = 0; k < 4; k++) push(9'd0, t);
        u = t;
        for (int k = 0; k < 4; k++) begin
            wait_vld(c);
            total++;
            if (c < 0) begin bad++; $display("FAIL zero_timeout: beat %0d got none want vld", k); end
            else begin
                if (c - u !== 1) begin bad++; $display("FAIL zero_lat: beat %0d got %0d want 1", k, c - u); end
                total++; if (bus.prob_mst_out !== 8'd0) begin bad++; $display("FAIL zero_prob: beat %0d got %0d want 0", k, bus.prob_mst_out); end
                total++; if (bus.last_mst_out !== (k == 3)) begin bad++; $display("FAIL zero_last: beat %0d got %b want %b", k, bus.last_mst_out, k == 3); end
                u = c;
            end
            @(negedge clk);
        end
`ifdef SOFTMAX_STATUS_EN
        total++; if (err_zero_sum !== 1'b1) begin bad++; $display("FAIL zero_err: got %b want 1", err_zero_sum); end
        total++; if (row_cnt !== 8'd1) begin bad++; $display("FAIL zero_cnt: got %0d want 1", row_cnt); end
`endif
    endtask

    task automatic test_uniform;
        int t, c, u;
        for (int k = 0; k < 4; k++) push(9'd64, t);
        u = t;
        for (int k = 0; k < 4; k++) begin
            wait_vld(c);
            total++;
            if (c < 0) begin bad++; $display("FAIL uni_timeout: beat %0d got none want vld", k); end
            else begin
                if (c - u !== 10) begin bad++; $display("FAIL uni_lat: beat %0d got %0d want 10", k, c - u); end
                total++; if (bus.prob_mst_out !== 8'd64) begin bad++; $display("FAIL uni_prob: beat %0d got %0d want 64", k, bus.prob_mst_out); end
                total++; if (bus.last_mst_out !== (k == 3)) begin bad++; $display("FAIL uni_last: beat %0d got %b want %b", k, bus.last_mst_out, k == 3); end
                u = c;
            end
            @(negedge clk);
        end
        total++; if (bus.rdy_slv_out !== 1'b1) begin bad++; $display("FAIL uni_rdy_after: got %b want 1", bus.rdy_slv_out); end
    endtask

    task automatic test_dominant;
        int t, c;
        int vals[4];
        int exp_p[4];
        vals  = '{448, 0, 0, 0};
        exp_p = '{255, 0, 0, 0};
        for (int k = 0; k < 4; k++) push(9'(vals[k]), t);
        for (int k = 0; k < 4; k++) begin
            wait_vld(c);
            total++;
            if (c < 0) begin bad++; $display("FAIL dom_timeout: beat %0d got none want vld", k); end
            else begin
                if (bus.prob_mst_out !== 8'(exp_p[k])) begin bad++; $display("FAIL dom_prob: beat %0d got %0d want %0d", k, bus.prob_mst_out, exp_p[k]); end
                total++; if (bus.last_mst_out !== (k == 3)) begin bad++; $display("FAIL dom_last: beat %0d got %b want %b", k, bus.last_mst_out, k == 3); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gaps;
        int t, c;
        int rdy_bad;
        int vals[4];
        vals = '{64, 128, 0, 64};
        rdy_bad = 0;
        for (int k = 0; k < 4; k++) begin
            push(9'(vals[k]), t);
            for (int g = 0; g <= k; g++) @(negedge clk);
        end
        // Hold junk on the input until the row drains; none of it may be taken.
        bus.ex_slv_in  = 9'd511;
        bus.vld_slv_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c = -1;
            for (int i = 0; i < 40; i++) begin
                if (bus.rdy_slv_out !== 1'b0) rdy_bad++;
                if (bus.vld_mst_out === 1'b1) begin c = cyc; break; end
                @(negedge clk);
            end
            total++;
            if (c < 0) begin bad++; $display("FAIL gap_timeout: beat %0d got none want vld", k); end
            else if (bus.prob_mst_out !== 8'(vals[k])) begin bad++; $display("FAIL gap_prob: beat %0d got %0d want %0d", k, bus.prob_mst_out, vals[k]); end
            @(negedge clk);
        end
        bus.vld_slv_in = 1'b0;
        total++; if (rdy_bad !== 0) begin bad++; $display("FAIL gap_rdy_low: got %0d cycles with rdy want 0", rdy_bad); end
        total++; if (bus.rdy_slv_out !== 1'b1) begin bad++; $display("FAIL gap_rdy_back: got %b want 1", bus.rdy_slv_out); end
    endtask

    task automatic test_backpressure;
        int t, c, u;
        int hold_bad;
        logic [7:0] p0;
        logic l0;
        int vals[4];
        int exp_p[4];
        vals  = '{100, 100, 50, 50};
        exp_p = '{85, 85, 42, 42};
        hold_bad = 0;
        bus.rdy_mst_in = 1'b0;
        for (int k = 0; k < 4; k++) push(9'(vals[k]), t);
        wait_vld(c);
        p0 = bus.prob_mst_out;
        l0 = bus.last_mst_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.vld_mst_out !== 1'b1 || bus.prob_mst_out !== p0 || bus.last_mst_out !== l0) hold_bad++;
        end
        total++; if (p0 !== 8'd85 || l0 !== 1'b0) begin bad++; $display("FAIL bp_first: got %0d/%b want 85/0", p0, l0); end
        total++; if (hold_bad !== 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); end
        bus.rdy_mst_in = 1'b1;
        u = cyc;
        @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            wait_vld(c);
            total++;
            if (c < 0) begin bad++; $display("FAIL bp_timeout: beat %0d got none want vld", k); end
            else begin
                if (c - u !== 10) begin bad++; $display("FAIL bp_lat: beat %0d got %0d want 10", k, c - u); end
                total++; if (bus.prob_mst_out !== 8'(exp_p[k])) begin bad++; $display("FAIL bp_prob: beat %0d got %0d want %0d", k, bus.prob_mst_out, exp_p[k]); end
                total++; if (bus.last_mst_out !== (k == 3)) begin bad++; $display("FAIL bp_last: beat %0d got %b want %b", k, bus.last_mst_out, k == 3); end
                u = c;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_div;
        int t, c;
        int vals[4];
        int exp_p[4];
        vals  = '{100, 100, 50, 50};
        exp_p = '{85, 85, 42, 42};
        for (int k = 0; k < 4; k++) push(9'd64, t);
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.rdy_slv_out !== 1'b0) begin bad++; $display("FAIL mid_in_div: got rdy %b want 0", bus.rdy_slv_out); end
        rst = 1'b1;
        #1;
        total++; if (bus.rdy_slv_out !== 1'b1) begin bad++; $display("FAIL mid_rdy: got %b want 1", bus.rdy_slv_out); end
        total++; if (bus.vld_mst_out !== 1'b0 || bus.last_mst_out !== 1'b0 || bus.prob_mst_out !== 8'd0) begin
            bad++; $display("FAIL mid_outs: got vld=%b last=%b prob=%0d want 0/0/0", bus.vld_mst_out, bus.last_mst_out, bus.prob_mst_out);
        end
`ifdef SOFTMAX_STATUS_EN
        total++; if (err_zero_sum !== 1'b0 || row_cnt !== 8'd0) begin bad++; $display("FAIL mid_status: got err=%b cnt=%0d want 0/0", err_zero_sum, row_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) push(9'(vals[k]), t);
        for (int k = 0; k < 4; k++) begin
            wait_vld(c);
            total++;
            if (c < 0) begin bad++; $display("FAIL post_timeout: beat %0d got none want vld", k); end
            else begin
                if (bus.prob_mst_out !== 8'(exp_p[k])) begin bad++; $display("FAIL post_prob: beat %0d got %0d want %0d", k, bus.prob_mst_out, exp_p[k]); end
                total++; if (bus.last_mst_out !== (k == 3)) begin bad++; $display("FAIL post_last: beat %0d got %b want %b", k, bus.last_mst_out, k == 3); end
            end
            @(negedge clk);
        end
`ifdef SOFTMAX_STATUS_EN
        total++; if (row_cnt !== 8'd1 || err_zero_sum !== 1'b0) begin bad++; $display("FAIL post_status: got cnt=%0d err=%b want 1/0", row_cnt, err_zero_sum); end
`endif
    endtask

    initial begin
        bus.ex_slv_in  = '0;
        bus.vld_slv_in = 1'b0;
        bus.rdy_mst_in = 1'b1;
        test_reset;
        test_zero_row;
        test_uniform;
        test_dominant;
        test_gaps;
        test_backpressure;
        test_reset_mid_div;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
